// File: rtl/id_lane_queue.sv
// N-lane in-order decode buffer: accepts up to LANES fetch lanes per cycle, presents the
// oldest entries and raises a branch redirect when a redirecting entry leaves the queue.
module id_lane_queue #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PC_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LANES-1:0]             pre_to_now_valid_i,
  input  logic [LANES*DATA_W-1:0]      pre_to_ibus,
  input  logic [LANES-1:0]             pre_redirect_i,
  input  logic [LANES*PC_W-1:0]        pre_target_i,
  output logic                         now_allowin_o,
  input  logic                         next_allowin_i,
  output logic [LANES-1:0]             now_to_next_valid_o,
  output logic [LANES*DATA_W-1:0]      to_next_obus,
  input  logic                         excep_flush_i,
  output logic                         branch_flush_o,
  output logic [PC_W-1:0]              branch_flush_pc_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         error_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned LW    = $clog2(LANES + 1);

  logic [DATA_W-1:0] payload_q [DEPTH];
  logic              redir_q   [DEPTH];
  logic [PC_W-1:0]   target_q  [DEPTH];

  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic              error_q;

  logic [AW-1:0]     rd_idx [LANES];
  logic [AW-1:0]     wr_idx [LANES];
  logic [LW-1:0]     n_raw, n, push_n, off;
  logic              brk_hit;
  logic [PC_W-1:0]   brk_tgt;
  logic              allowin, any_valid, contig, push, pop, bflush, err_set;

  assign allowin   = (CNT_W'(DEPTH) - count_q) >= CNT_W'(LANES);
  assign any_valid = |pre_to_now_valid_i;
  assign contig    = (pre_to_now_valid_i & (pre_to_now_valid_i + LANES'(1))) == '0;
  assign push      = allowin & any_valid & ~excep_flush_i & ~bflush;
  assign pop       = next_allowin_i & ~excep_flush_i;
  assign bflush    = pop & brk_hit;
  assign err_set   = (push & ~contig) | (~allowin & any_valid);

  // Presented group: oldest entries, cut just after the first redirecting entry.
  always_comb begin
    n_raw   = (count_q >= CNT_W'(LANES)) ? LW'(LANES) : LW'(count_q);
    n       = n_raw;
    brk_hit = 1'b0;
    brk_tgt = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_idx[k] = AW'(head_q + PTR_W'(k));
    end
    for (int k = 0; k < LANES; k++) begin
      if (!brk_hit && (LW'(k) < n_raw) && redir_q[rd_idx[k]]) begin
        brk_hit = 1'b1;
        n       = LW'(k + 1);
        brk_tgt = target_q[rd_idx[k]];
      end
    end
  end

  always_comb begin
    now_to_next_valid_o = '0;
    to_next_obus        = '0;
    for (int k = 0; k < LANES; k++) begin
      if (LW'(k) < n) begin
        now_to_next_valid_o[k]          = ~excep_flush_i;
        to_next_obus[k*DATA_W +: DATA_W] = payload_q[rd_idx[k]];
      end
    end
  end

  // Valid lanes pack densely from tail in lane order.
  always_comb begin
    off = '0;
    for (int k = 0; k < LANES; k++) begin
      wr_idx[k] = AW'(tail_q + PTR_W'(off));
      if (pre_to_now_valid_i[k]) off = off + LW'(1);
    end
    push_n = off;
  end

  assign now_allowin_o     = allowin;
  assign branch_flush_o    = bflush;
  assign branch_flush_pc_o = bflush ? brk_tgt : '0;
  assign count_o           = count_q;
  assign error_o           = error_q;

  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < LANES; k++) begin
        if (pre_to_now_valid_i[k]) begin
          payload_q[wr_idx[k]] <= pre_to_ibus[k*DATA_W +: DATA_W];
          redir_q[wr_idx[k]]   <= pre_redirect_i[k];
          target_q[wr_idx[k]]  <= pre_target_i[k*PC_W +: PC_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (err_set) error_q <= 1'b1;
      if (excep_flush_i || bflush) begin
        head_q  <= tail_q;
        count_q <= '0;
      end else begin
        head_q  <= head_q + PTR_W'(pop ? n : LW'(0));
        tail_q  <= tail_q + PTR_W'(push ? push_n : LW'(0));
        count_q <= count_q + CNT_W'(push ? push_n : LW'(0)) - CNT_W'(pop ? n : LW'(0));
      end
    end
  end

endmodule
